// File: rtl/sys_defs_pkg.sv
// sys_defs: shared front-end types and instruction buffer sizing
`ifndef N
`define N 3
`endif
package sys_defs;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } INST_PACKET;
  localparam int IB_DEPTH = 16;
  localparam int IB_IDX_W = $clog2(IB_DEPTH);
  localparam int IB_CNT_W = $clog2(IB_DEPTH + 1);
endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and dispatch
module inst_buffer
  import sys_defs::*;
#(
  parameter int N = `N,
  parameter int DEPTH = IB_DEPTH,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int NW = $clog2(N + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  INST_PACKET [N-1:0]  in_insts,
  input  logic [NW-1:0]       num_in,
  input  logic [NW-1:0]       num_dispatch,
  input  logic                flush,
  output INST_PACKET [N-1:0]  out_insts,
  output logic [NW-1:0]       num_accepted,
  output logic [CW-1:0]       free_slots,
  output logic [CW-1:0]       count
);
  function automatic logic [CW-1:0] min_cnt(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return a < b ? a : b;
  endfunction
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, free_q, free_d, pops, acc;
  INST_PACKET entries_q [DEPTH];
  INST_PACKET entries_d [DEPTH];
  assign count = count_q;
  assign free_slots = free_q;
  assign num_accepted = NW'(acc);
  // Room is judged on start-of-cycle occupancy so num_dispatch never reaches num_accepted
  always_comb begin
    pops = flush ? '0 : min_cnt(min_cnt(CW'(num_dispatch), count_q), CW'(N));
    acc = (reset || flush) ? '0 : min_cnt(CW'(num_in), free_q);
    entries_d = entries_q;
    for (int i = 0; i < N; i++)
      if (CW'(i) < acc) entries_d[tail_q + IW'(i)] = in_insts[i];
    head_d = flush ? '0 : head_q + IW'(pops);
    tail_d = flush ? '0 : tail_q + IW'(acc);
    count_d = flush ? '0 : count_q + acc - pops;
    free_d = CW'(DEPTH) - count_d;
  end
  // Oldest entries from head, lanes beyond the occupancy masked invalid
  always_comb begin
    out_insts = '0;
    for (int i = 0; i < N; i++) begin
      out_insts[i] = entries_q[head_q + IW'(i)];
      out_insts[i].valid = entries_q[head_q + IW'(i)].valid && (CW'(i) < count_q);
    end
  end
  // Pointer, occupancy and storage registers
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      free_q <= CW'(DEPTH);
      entries_q <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      free_q <= free_d;
      entries_q <= entries_d;
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed table-driven check of inst_buffer with N=3, DEPTH=8
module tb_inst_buffer;
  import sys_defs::*;
  localparam int N = 3;
  localparam int DEPTH = 8;
  logic clock = 0, reset = 1, flush = 0;
  INST_PACKET [N-1:0] in_insts, out_insts;
  logic [1:0] num_in = 0, num_dispatch = 0, num_accepted;
  logic [3:0] free_slots, count;
  int checks = 0, failures = 0;
  typedef struct {
    logic rst, fl;
    int nin, nd, base, acc, cnt, fr;
    logic [2:0] vm;
    int t0, t1, t2;
  } vec_t;
  vec_t v [17];
  always #5 clock = ~clock;
  inst_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_insts(in_insts), .num_in(num_in),
    .num_dispatch(num_dispatch), .flush(flush), .out_insts(out_insts),
    .num_accepted(num_accepted), .free_slots(free_slots), .count(count)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic f, input int nin, input int nd, input int base);
    reset = r;
    flush = f;
    num_in = 2'(nin);
    num_dispatch = 2'(nd);
    for (int i = 0; i < N; i++) begin
      in_insts[i].valid = 1'b1;
      in_insts[i].pc = 32'((base + i) * 4);
      in_insts[i].inst = 32'(base + i);
    end
  endtask
  initial begin
    int tags [3];
    int total, cyc;
    v[0]  = '{1, 0, 3, 0, 16, 0, 0, 8, 3'b000, 0, 0, 0};
    v[1]  = '{0, 0, 3, 0, 1, 3, 3, 5, 3'b111, 1, 2, 3};
    v[2]  = '{0, 0, 3, 2, 4, 3, 4, 4, 3'b111, 3, 4, 5};
    v[3]  = '{0, 0, 3, 0, 7, 3, 7, 1, 3'b111, 3, 4, 5};
    v[4]  = '{0, 0, 3, 0, 10, 1, 8, 0, 3'b111, 3, 4, 5};
    v[5]  = '{0, 0, 3, 0, 13, 0, 8, 0, 3'b111, 3, 4, 5};
    v[6]  = '{0, 0, 3, 3, 13, 0, 5, 3, 3'b111, 6, 7, 8};
    v[7]  = '{0, 0, 0, 1, 0, 0, 4, 4, 3'b111, 7, 8, 9};
    v[8]  = '{0, 0, 0, 2, 0, 0, 2, 6, 3'b011, 9, 10, 0};
    v[9]  = '{0, 0, 3, 0, 20, 3, 5, 3, 3'b111, 9, 10, 20};
    v[10] = '{0, 1, 3, 2, 30, 0, 0, 8, 3'b000, 0, 0, 0};
    v[11] = '{0, 0, 0, 3, 0, 0, 0, 8, 3'b000, 0, 0, 0};
    v[12] = '{0, 0, 3, 0, 40, 3, 3, 5, 3'b111, 40, 41, 42};
    v[13] = '{0, 0, 3, 0, 43, 3, 6, 2, 3'b111, 40, 41, 42};
    v[14] = '{1, 0, 3, 1, 50, 0, 0, 8, 3'b000, 0, 0, 0};
    v[15] = '{0, 0, 2, 0, 50, 2, 2, 6, 3'b011, 50, 51, 0};
    v[16] = '{0, 0, 0, 3, 0, 0, 0, 8, 3'b000, 0, 0, 0};
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      drive(v[k].rst, v[k].fl, v[k].nin, v[k].nd, v[k].base);
      #1;
      chk($sformatf("row%0d num_accepted", k), int'(num_accepted), v[k].acc);
      @(posedge clock);
      #1;
      chk($sformatf("row%0d count", k), int'(count), v[k].cnt);
      chk($sformatf("row%0d free_slots", k), int'(free_slots), v[k].fr);
      tags = '{v[k].t0, v[k].t1, v[k].t2};
      for (int i = 0; i < N; i++) begin
        chk($sformatf("row%0d lane%0d valid", k, i), int'(out_insts[i].valid), int'(v[k].vm[i]));
        if (v[k].vm[i]) chk($sformatf("row%0d lane%0d inst", k, i), int'(out_insts[i].inst), tags[i]);
      end
    end
    total = 0;
    cyc = 0;
    do begin
      @(negedge clock);
      drive(0, 0, 3, 0, 60 + total);
      #1;
      total += int'(num_accepted);
      cyc++;
    end while (num_accepted != 0 && cyc < 10);
    chk("fill accepted total", total, 8);
    chk("fill cycles", cyc, 4);
    @(posedge clock);
    #1;
    chk("fill count", int'(count), 8);
    chk("fill free", int'(free_slots), 0);
    chk("fill lane0", int'(out_insts[0].inst), 60);
    @(negedge clock);
    drive(0, 1, 3, 3, 90);
    #1;
    chk("full flush accepted", int'(num_accepted), 0);
    @(posedge clock);
    #1;
    chk("full flush count", int'(count), 0);
    chk("full flush lane0 valid", int'(out_insts[0].valid), 0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
